// File: rtl/cnn_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_gen_if
// Description : Pixel-in / window-out handshake bundle for cnn_window_gen.
//               The slave modport is the window generator; the master modport
//               is the pixel producer plus the window consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnn_window_gen_if #(
    parameter int K      = 3,
    parameter int DATA_W = 1
) ();
    logic                    pix_vld;
    logic [DATA_W-1:0]       pix_in;
    logic                    pix_rdy;
    logic                    win_vld;
    logic                    win_rdy;
    logic [K*K*DATA_W-1:0]   win_data;
    logic                    frame_done;
    logic                    busy;

    modport slave (
        input  pix_vld, pix_in, win_rdy,
        output pix_rdy, win_vld, win_data, frame_done, busy
    );

    modport master (
        output pix_vld, pix_in, win_rdy,
        input  pix_rdy, win_vld, win_data, frame_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/cnn_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_gen
// Description : Streaming K x K sliding-window generator. Raster pixels are
//               pushed through K-1 circular line buffers and a K x K shift
//               array; each complete window is handed out as one packed word
//               through a single-entry output register with backpressure.
//               Optional macro CNN_WIN_POS_EN adds win_row/win_col (window
//               top-left coordinate) and a sticky ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int DATA_W = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    cnn_window_gen_if.slave             bus
`ifdef CNN_WIN_POS_EN
    ,
    output logic [$clog2(IMG_H)-1:0]    win_row,
    output logic [$clog2(IMG_W)-1:0]    win_col,
    output logic                        ovf
`endif
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam int c_WIN_W = K*K*DATA_W;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W-1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H-1);
    localparam logic [c_COL_W-1:0] c_COL_FULL = c_COL_W'(K-1);
    localparam logic [c_ROW_W-1:0] c_ROW_FULL = c_ROW_W'(K-1);

    localparam logic [1:0] c_FILL   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic                r_win_vld;
    logic [c_WIN_W-1:0]  r_win_data;
    logic                r_frame_done;
    logic                r_busy;

    logic [DATA_W-1:0]   r_lb  [0:K-2][0:IMG_W-1];
    logic [DATA_W-1:0]   r_win [0:K-1][0:K-1];

    logic [DATA_W-1:0]   w_col_vec  [0:K-1];
    logic [DATA_W-1:0]   w_win_next [0:K-1][0:K-1];
    logic [c_WIN_W-1:0]  w_win_pack;

    logic                w_pix_rdy;
    logic                w_accept;
    logic                w_take;
    logic                w_last_pix;
    logic                w_trig;

    // Input is held off in DRAIN/DONE and while an untaken window blocks the output slot
    assign w_pix_rdy  = ((r_state == c_FILL) || (r_state == c_STREAM)) && (!r_win_vld || bus.win_rdy);
    // A pixel offered alongside clr is dropped
    assign w_accept   = bus.pix_vld && w_pix_rdy && !clr;
    assign w_take     = r_win_vld && bus.win_rdy;
    assign w_last_pix = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_trig     = w_accept && (r_row >= c_ROW_FULL) && (r_col >= c_COL_FULL);

    // Column entering the window: line-buffer taps for the upper rows, live pixel at the bottom
    generate
        for (genvar r = 0; r < K; r++) begin : g_row
            if (r < K-1) begin : g_tap
                assign w_col_vec[r] = r_lb[K-2-r][r_col];
            end else begin : g_live
                assign w_col_vec[r] = bus.pix_in;
            end
            for (genvar c = 0; c < K; c++) begin : g_col
                if (c < K-1) begin : g_shift
                    assign w_win_next[r][c] = r_win[r][c+1];
                end else begin : g_load
                    assign w_win_next[r][c] = w_col_vec[r];
                end
                assign w_win_pack[(r*K+c)*DATA_W +: DATA_W] = w_win_next[r][c];
            end
        end
    endgenerate

    // Line buffers cascade one row per stage; shift array moves left on every accepted pixel
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= bus.pix_in;
            for (int i = 1; i < K-1; i++) begin
                r_lb[i][r_col] <= r_lb[i-1][r_col];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= w_win_next[r][c];
                end
            end
        end
    end

    // Raster counters, output register, frame state and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_win_vld    <= 1'b0;
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else if (clr) begin
            r_state      <= c_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_trig) begin
                r_win_vld  <= 1'b1;
                r_win_data <= w_win_pack;
            end else if (w_take) begin
                r_win_vld  <= 1'b0;
            end
            case (r_state)
                c_FILL: begin
                    // A frame no larger than the kernel ends on its first window
                    if (w_trig) begin
                        r_state <= w_last_pix ? c_DRAIN : c_STREAM;
                    end
                end
                c_STREAM: begin
                    if (w_accept && w_last_pix) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_take) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_DONE;
                end
            endcase
        end
    end

`ifdef CNN_WIN_POS_EN
    logic [c_ROW_W-1:0] r_win_row;
    logic [c_COL_W-1:0] r_win_col;
    logic               r_ovf;

    // Window coordinate travels with the data; ovf latches pixels offered after the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_row <= '0;
            r_win_col <= '0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_ovf     <= 1'b0;
        end else begin
            if (w_trig) begin
                r_win_row <= r_row - c_ROW_FULL;
                r_win_col <= r_col - c_COL_FULL;
            end
            if (bus.pix_vld && (r_state == c_DONE)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign win_row = r_win_row;
    assign win_col = r_win_col;
    assign ovf     = r_ovf;
`endif

    assign bus.pix_rdy    = w_pix_rdy;
    assign bus.win_vld    = r_win_vld;
    assign bus.win_data   = r_win_data;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cnn_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_window_gen
// Description : Scoreboard bench for cnn_window_gen. DUT A uses the default
//               28x28/K3/1-bit geometry, DUT B a 5x4/K3/8-bit geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr_a;
    logic clr_b;

    cnn_window_gen_if #(.K(3), .DATA_W(1)) bus_a ();
    cnn_window_gen_if #(.K(3), .DATA_W(8)) bus_b ();

`ifdef CNN_WIN_POS_EN
    logic [4:0] row_a;
    logic [4:0] col_a;
    logic       ovf_a;
    logic [1:0] row_b;
    logic [2:0] col_b;
    logic       ovf_b;
    logic [1:0] last_row_b;
    logic [2:0] last_col_b;
`endif

    cnn_window_gen #(.IMG_W(28), .IMG_H(28), .K(3), .DATA_W(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_a),
        .bus     (bus_a)
`ifdef CNN_WIN_POS_EN
        ,
        .win_row (row_a),
        .win_col (col_a),
        .ovf     (ovf_a)
`endif
    );

    cnn_window_gen #(.IMG_W(5), .IMG_H(4), .K(3), .DATA_W(8)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_b),
        .bus     (bus_b)
`ifdef CNN_WIN_POS_EN
        ,
        .win_row (row_b),
        .win_col (col_b),
        .ovf     (ovf_b)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int win_a  = 0;
    int win_b  = 0;
    int fd_a   = 0;
    int fd_b   = 0;
    logic [127:0] q_a [$];
    logic [127:0] q_b [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected 3x3 window whose bottom-right pixel is (r,c); pixel value = raster index bits
    function automatic logic [127:0] exp_win(input int w, input int dw, input int r, input int c);
        logic [127:0] v;
        int idx;
        v = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                idx = (r-2+rr)*w + (c-2+cc);
                for (int b = 0; b < dw; b++) v[(rr*3+cc)*dw+b] = idx[b];
            end
        end
        return v;
    endfunction

    // Monitor A: pop and compare on every handed-off window
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.frame_done) fd_a++;
            if (bus_a.win_vld && bus_a.win_rdy) begin
                if (q_a.size() == 0) check("a_extra_window", 128'(q_a.size()), 128'd1);
                else check("a_window", bus_a.win_data, q_a.pop_front());
                win_a++;
            end
        end
    end

    // Monitor B: pop and compare, plus the hand-computed window 3
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_b.frame_done) fd_b++;
            if (bus_b.win_vld && bus_b.win_rdy) begin
                if (win_b == 3) check("b_window3", bus_b.win_data, 72'h11100F0C0B0A070605);
                if (q_b.size() == 0) check("b_extra_window", 128'(q_b.size()), 128'd1);
                else check("b_window", bus_b.win_data, q_b.pop_front());
`ifdef CNN_WIN_POS_EN
                last_row_b = row_b;
                last_col_b = col_b;
`endif
                win_b++;
            end
        end
    end

    task automatic send_a(input int npix, input bit clr_end);
        for (int i = 0; i < npix; i++) begin
            int t;
            int r;
            int c;
            r = i / 28;
            c = i % 28;
            bus_a.pix_vld = 1'b1;
            bus_a.pix_in  = i[0];
            t = 0;
            @(negedge clk);
            while (!bus_a.pix_rdy && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                check("a_pix_rdy_timeout", 128'(t), 128'd0);
                bus_a.pix_vld = 1'b0;
                return;
            end
            if (r >= 2 && c >= 2) q_a.push_back(exp_win(28, 1, r, c));
            @(posedge clk);
            #1;
            if (i == 57) check("a_no_win_before_58", 128'(bus_a.win_vld), 128'd0);
            if (i == 58) begin
                check("a_first_win_vld", 128'(bus_a.win_vld), 128'd1);
                check("a_first_win_data", 128'(bus_a.win_data), 128'h092);
                check("a_busy_mid_frame", 128'(bus_a.busy), 128'd1);
            end
        end
        bus_a.pix_vld = 1'b0;
        if (clr_end) begin
            clr_a = 1'b1;
            @(posedge clk);
            #1;
            clr_a = 1'b0;
        end
    endtask

    task automatic wait_fd_a(input int prev);
        int t;
        t = 0;
        while (fd_a == prev && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("a_frame_done_once", 128'(fd_a), 128'(prev + 1));
    endtask

    // Hold win_rdy low for 10 cycles while window number target is presented
    task automatic stall_a(input int target);
        int t;
        logic [8:0] hold;
        t = 0;
        @(posedge clk);
        #2;
        while (!(win_a == target && bus_a.win_vld) && t < 5000) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 5000) begin
            check("a_stall_timeout", 128'(t), 128'd0);
            return;
        end
        bus_a.win_rdy = 1'b0;
        hold = bus_a.win_data;
        repeat (10) begin
            @(negedge clk);
            check("a_stall_data_stable", 128'(bus_a.win_data), 128'(hold));
            check("a_stall_pix_rdy", 128'(bus_a.pix_rdy), 128'd0);
        end
        @(posedge clk);
        #2;
        bus_a.win_rdy = 1'b1;
    endtask

    task automatic pulse_clr_a();
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fd0;
        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        bus_a.pix_vld = 1'b0;
        bus_a.pix_in  = '0;
        bus_a.win_rdy = 1'b1;
        bus_b.pix_vld = 1'b0;
        bus_b.pix_in  = '0;
        bus_b.win_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("a_reset_win_vld", 128'(bus_a.win_vld), 128'd0);
        check("a_reset_win_data", 128'(bus_a.win_data), 128'd0);
        check("a_reset_frame_done", 128'(bus_a.frame_done), 128'd0);
        check("a_reset_busy", 128'(bus_a.busy), 128'd0);
        check("a_reset_pix_rdy", 128'(bus_a.pix_rdy), 128'd1);
        check("b_reset_win_vld", 128'(bus_b.win_vld), 128'd0);
        check("b_reset_win_data", 128'(bus_b.win_data), 128'd0);

        // Small geometry: 20 pixels, pixel value = index
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            int t;
            bus_b.pix_vld = 1'b1;
            bus_b.pix_in  = i[7:0];
            t = 0;
            @(negedge clk);
            while (!bus_b.pix_rdy && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("b_pix_rdy_timeout", 128'(t), 128'd0);
            if ((i / 5) >= 2 && (i % 5) >= 2) q_b.push_back(exp_win(5, 8, i / 5, i % 5));
            @(posedge clk);
            #1;
        end
        bus_b.pix_vld = 1'b0;
        repeat (5) @(negedge clk);
        check("b_window_count", 128'(win_b), 128'd6);
        check("b_frame_done_once", 128'(fd_b), 128'd1);
        check("b_pix_rdy_after_done", 128'(bus_b.pix_rdy), 128'd0);
`ifdef CNN_WIN_POS_EN
        check("b_last_win_row", 128'(last_row_b), 128'd1);
        check("b_last_win_col", 128'(last_col_b), 128'd2);
        @(posedge clk);
        #1;
        bus_b.pix_vld = 1'b1;
        @(posedge clk);
        #1;
        bus_b.pix_vld = 1'b0;
        check("b_ovf_set", 128'(ovf_b), 128'd1);
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        clr_b = 1'b0;
        check("b_ovf_cleared", 128'(ovf_b), 128'd0);
`endif

        // Frame 1: full-rate, no backpressure
        @(posedge clk);
        #1;
        base = win_a;
        fd0  = fd_a;
        send_a(784, 1'b0);
        wait_fd_a(fd0);
        check("a_frame1_windows", 128'(win_a - base), 128'd676);
        @(posedge clk);
        #1;
        bus_a.pix_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("a_done_pix_rdy", 128'(bus_a.pix_rdy), 128'd0);
        end
        check("a_done_busy", 128'(bus_a.busy), 128'd0);
        bus_a.pix_vld = 1'b0;

        // Frame 2: backpressure at window 5
        pulse_clr_a();
        check("a_clr_pix_rdy", 128'(bus_a.pix_rdy), 128'd1);
        @(posedge clk);
        #1;
        base = win_a;
        fd0  = fd_a;
        fork
            send_a(784, 1'b0);
            stall_a(base + 5);
        join
        wait_fd_a(fd0);
        check("a_frame2_windows", 128'(win_a - base), 128'd676);

        // Abort after pixel 300, then a fresh frame
        pulse_clr_a();
        @(posedge clk);
        #1;
        send_a(301, 1'b0);
        bus_a.pix_vld = 1'b1;
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        bus_a.pix_vld = 1'b0;
        @(negedge clk);
        check("a_abort_win_vld", 128'(bus_a.win_vld), 128'd0);
        check("a_abort_busy", 128'(bus_a.busy), 128'd0);
        check("a_abort_queue_empty", 128'(q_a.size()), 128'd0);
        q_a.delete();
        @(posedge clk);
        #1;
        base = win_a;
        fd0  = fd_a;
        send_a(784, 1'b0);
        wait_fd_a(fd0);
        check("a_frame3_windows", 128'(win_a - base), 128'd676);

        // clr coinciding with the final window take
        pulse_clr_a();
        @(posedge clk);
        #1;
        fd0 = fd_a;
        send_a(784, 1'b1);
        repeat (5) @(negedge clk);
        check("a_clr_take_no_done", 128'(fd_a), 128'(fd0));
        check("a_clr_take_fill_rdy", 128'(bus_a.pix_rdy), 128'd1);
        check("a_clr_take_win_vld", 128'(bus_a.win_vld), 128'd0);
        check("a_clr_take_busy", 128'(bus_a.busy), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
